chip_link_rx: RTL and testbench



---
 rtl/pcss_link_pkg.sv | 19 +
 rtl/pcss_pkt_fifo.sv | 64 ++++++
 rtl/chip_link_rx.sv | 147 ++++++++++++++
 tb/tb_chip_link_rx.sv | 201 ++++++++++++++++++++
 4 files changed

// File: rtl/pcss_link_pkg.sv
// Shared definitions for the pcss chip-edge link: flit/packet geometry,
// link FSM states and the flit parity function used by both link directions.
package pcss_link_pkg;

    localparam int CHIPDATA_WIDTH = 16;
    localparam int FLITS          = 4;
    localparam int PKT_W          = FLITS * CHIPDATA_WIDTH;

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        ACK  = 1'b1
    } link_state_e;

    // Even-XOR parity: the sender drives the XOR of all flit bits.
    function automatic logic link_parity(input logic [CHIPDATA_WIDTH-1:0] data);
        return ^data;
    endfunction

endpackage

// File: rtl/pcss_pkt_fifo.sv
// Parameterised DEPTH x WIDTH synchronous circular FIFO (power-of-two DEPTH)
// shared by the link receive and transmit sides.
module pcss_pkt_fifo #(
    parameter int DEPTH = 2,
    parameter int WIDTH = 64
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             push,
    input  logic [WIDTH-1:0] push_data,
    input  logic             pop,
    output logic [WIDTH-1:0] pop_data,
    output logic             full,
    output logic             empty
);
    import pcss_link_pkg::*;

    localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int CNT_W = $clog2(DEPTH + 1);
    localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);
    localparam logic [PTR_W-1:0] PTR_ONE  = PTR_W'(1);

    logic [WIDTH-1:0] mem_r [DEPTH];
    logic [PTR_W-1:0] rd_ptr_r;
    logic [PTR_W-1:0] wr_ptr_r;
    logic [CNT_W-1:0] count_r;
    logic             do_pop_s;
    logic             do_push_s;

    // A pop while full frees the slot the same cycle, so push is allowed then.
    assign do_pop_s  = pop && (count_r != {CNT_W{1'b0}});
    assign do_push_s = push && ((count_r != FULL_CNT) || do_pop_s);

    assign pop_data = mem_r[rd_ptr_r];
    assign full     = (count_r == FULL_CNT);
    assign empty    = (count_r == {CNT_W{1'b0}});

    // Storage, pointers and occupancy count.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                mem_r[i] <= {WIDTH{1'b0}};
            end
            rd_ptr_r <= {PTR_W{1'b0}};
            wr_ptr_r <= {PTR_W{1'b0}};
            count_r  <= {CNT_W{1'b0}};
        end else begin
            if (do_push_s) begin
                mem_r[wr_ptr_r] <= push_data;
                wr_ptr_r        <= wr_ptr_r + PTR_ONE;
            end
            if (do_pop_s) begin
                rd_ptr_r <= rd_ptr_r + PTR_ONE;
            end
            case ({do_push_s, do_pop_s})
                2'b10:   count_r <= count_r + CNT_ONE;
                2'b01:   count_r <= count_r - CNT_ONE;
                default: count_r <= count_r;
            endcase
        end
    end

endmodule

// File: rtl/chip_link_rx.sv
// Chip-edge receive deserializer: 4-phase flit handshake, MSB-flit-first
// packet assembly into a small output FIFO. Parity check/drop is enabled by
// defining LINK_PARITY_CHECK_EN.
module chip_link_rx #(
    parameter int CHIPDATA_WIDTH = pcss_link_pkg::CHIPDATA_WIDTH,
    parameter int PKT_W          = pcss_link_pkg::PKT_W,
    parameter int FLITS          = pcss_link_pkg::FLITS,
    parameter int DEPTH          = 2,
    parameter int CNT_W          = 8
) (
    input  logic                      clk,
    input  logic                      rst_n,
    input  logic [CHIPDATA_WIDTH-1:0] recv_data_in,
    input  logic                      recv_data_valid,
    input  logic                      recv_data_par,
    output logic                      recv_data_ready,
    output logic                      recv_data_err,
    output logic [PKT_W-1:0]          pkt_data,
    output logic                      pkt_valid,
    input  logic                      pkt_ready,
    output logic [CNT_W-1:0]          drop_cnt
);
    import pcss_link_pkg::*;

    localparam int FC_W = (FLITS > 1) ? $clog2(FLITS) : 1;
    localparam logic [FC_W-1:0] LAST_FLIT = FC_W'(FLITS - 1);
    localparam logic [FC_W-1:0] FC_ONE    = FC_W'(1);

    link_state_e         state_r;
    logic [FC_W-1:0]     flit_cnt_r;
    logic [PKT_W-1:0]    shift_r;
    logic                ready_r;
    logic                err_r;
    logic [PKT_W-1:0]    pkt_s;
    logic                accept_s;
    logic                last_s;
    logic                perr_s;
    logic                keep_s;
    logic                push_s;
    logic                fifo_full_s;
    logic                fifo_empty_s;

    // Full is judged from the registered count only; no pop bypass.
    assign last_s   = (flit_cnt_r == LAST_FLIT);
    assign accept_s = (state_r == IDLE) && recv_data_valid && (!last_s || !fifo_full_s);
    assign push_s   = accept_s && last_s && keep_s;

    // Packet image with the incoming flit placed in slot flit_cnt.
    always_comb begin
        pkt_s = shift_r;
        for (int i = 0; i < FLITS; i++) begin
            if (flit_cnt_r == FC_W'(i)) begin
                pkt_s[PKT_W-1-i*CHIPDATA_WIDTH -: CHIPDATA_WIDTH] = recv_data_in;
            end else begin
                pkt_s[PKT_W-1-i*CHIPDATA_WIDTH -: CHIPDATA_WIDTH] =
                    shift_r[PKT_W-1-i*CHIPDATA_WIDTH -: CHIPDATA_WIDTH];
            end
        end
    end

`ifdef LINK_PARITY_CHECK_EN
    logic             bad_r;
    logic [CNT_W-1:0] drop_r;

    assign perr_s   = link_parity(recv_data_in) ^ recv_data_par;
    assign keep_s   = !(bad_r | perr_s);
    assign drop_cnt = drop_r;

    // Sticky per-packet error flag and saturating drop counter.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            bad_r  <= 1'b0;
            drop_r <= {CNT_W{1'b0}};
        end else if (accept_s) begin
            if (last_s) begin
                bad_r <= 1'b0;
                if (!keep_s && (drop_r != {CNT_W{1'b1}})) begin
                    drop_r <= drop_r + CNT_W'(1);
                end
            end else begin
                bad_r <= bad_r | perr_s;
            end
        end
    end
`else
    logic unused_par_s;

    assign unused_par_s = recv_data_par;
    assign perr_s       = 1'b0;
    assign keep_s       = 1'b1;
    assign drop_cnt     = {CNT_W{1'b0}};
`endif

    // Link handshake FSM, flit counter and assembly register.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_r    <= IDLE;
            flit_cnt_r <= {FC_W{1'b0}};
            shift_r    <= {PKT_W{1'b0}};
            ready_r    <= 1'b0;
            err_r      <= 1'b0;
        end else begin
            case (state_r)
                IDLE: begin
                    if (accept_s) begin
                        state_r    <= ACK;
                        ready_r    <= 1'b1;
                        err_r      <= perr_s;
                        shift_r    <= pkt_s;
                        flit_cnt_r <= last_s ? {FC_W{1'b0}} : flit_cnt_r + FC_ONE;
                    end
                end
                ACK: begin
                    if (!recv_data_valid) begin
                        state_r <= IDLE;
                        ready_r <= 1'b0;
                        err_r   <= 1'b0;
                    end
                end
                default: begin
                    state_r <= IDLE;
                    ready_r <= 1'b0;
                    err_r   <= 1'b0;
                end
            endcase
        end
    end

    assign recv_data_ready = ready_r;
    assign recv_data_err   = err_r;
    assign pkt_valid       = !fifo_empty_s;

    pcss_pkt_fifo #(
        .DEPTH (DEPTH),
        .WIDTH (PKT_W)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push_s),
        .push_data (pkt_s),
        .pop       (pkt_ready),
        .pop_data  (pkt_data),
        .full      (fifo_full_s),
        .empty     (fifo_empty_s)
    );

endmodule

// File: tb/tb_chip_link_rx.sv
// Self-checking bench for chip_link_rx: packet-level model (expected packet
// queue, drop count) compared every cycle, plus literal pins of key results.
module tb_chip_link_rx;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic [15:0] recv_data_in = 16'h0000;
    logic        recv_data_valid = 1'b0;
    logic        recv_data_par = 1'b0;
    logic        recv_data_ready;
    logic        recv_data_err;
    logic [63:0] pkt_data;
    logic        pkt_valid;
    logic        pkt_ready = 1'b1;
    logic [7:0]  drop_cnt;

    always #5 clk = ~clk;

    chip_link_rx dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .recv_data_in    (recv_data_in),
        .recv_data_valid (recv_data_valid),
        .recv_data_par   (recv_data_par),
        .recv_data_ready (recv_data_ready),
        .recv_data_err   (recv_data_err),
        .pkt_data        (pkt_data),
        .pkt_valid       (pkt_valid),
        .pkt_ready       (pkt_ready),
        .drop_cnt        (drop_cnt)
    );

    int          n_total = 0;
    int          n_pass  = 0;
    logic [63:0] exp_q[$];
    logic [63:0] cur_pkt = 64'h0;
    int          cur_n   = 0;
    logic        cur_bad = 1'b0;
    int          exp_drop = 0;
    logic        exp_err = 1'b0;
    logic        chk_en  = 1'b0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_total++;
        if (act === exp) begin
            n_pass++;
        end else begin
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    // Packet-level model update for one accepted flit.
    task automatic model_accept(input logic [15:0] data, input logic flip);
        cur_pkt[63-16*cur_n -: 16] = data;
`ifdef LINK_PARITY_CHECK_EN
        cur_bad = cur_bad | flip;
        exp_err = flip;
`else
        exp_err = 1'b0;
`endif
        cur_n++;
        if (cur_n == 4) begin
            if (!cur_bad) exp_q.push_back(cur_pkt);
            else if (exp_drop < 255) exp_drop++;
            cur_n   = 0;
            cur_bad = 1'b0;
        end
    endtask

    // Every-cycle comparison against the model.
    always @(negedge clk) begin
        if (chk_en && rst_n) begin
            check("pkt_valid", {63'h0, pkt_valid}, {63'h0, exp_q.size() != 0});
            if (pkt_valid && exp_q.size() != 0) begin
                check("pkt_data", pkt_data, exp_q[0]);
                if (pkt_ready) void'(exp_q.pop_front());
            end
            check("drop_cnt", {56'h0, drop_cnt}, 64'(exp_drop));
            check("recv_data_err", {63'h0, recv_data_err},
                  {63'h0, recv_data_ready ? exp_err : 1'b0});
        end
    end

    task automatic send_flit(input logic [15:0] data, input logic flip,
                             input int hold, input int stall);
        logic got;
        recv_data_in    = data;
        recv_data_par   = (^data) ^ flip;
        recv_data_valid = 1'b1;
        if (stall > 0) begin
            repeat (stall) begin
                @(posedge clk); #1;
                check("bp_ready_low", {63'h0, recv_data_ready}, 64'h0);
            end
            pkt_ready = 1'b1;
        end
        got = 1'b0;
        for (int i = 0; i < 20 && !got; i++) begin
            @(posedge clk); #1;
            got = recv_data_ready;
        end
        check("ready_rise", {63'h0, recv_data_ready}, 64'h1);
        if (got) model_accept(data, flip);
        recv_data_in  = 16'hDEAD;
        recv_data_par = ~recv_data_par;
        repeat (hold) begin
            @(posedge clk); #1;
            check("ready_hold", {63'h0, recv_data_ready}, 64'h1);
        end
        recv_data_valid = 1'b0;
        @(posedge clk); #1;
        check("ready_fall", {63'h0, recv_data_ready}, 64'h0);
    endtask

    task automatic send_pkt(input logic [63:0] pkt, input int flip_idx, input int stall);
        for (int k = 0; k < 4; k++) begin
            send_flit(pkt[63-16*k -: 16], k == flip_idx, 0, (k == 3) ? stall : 0);
        end
    endtask

    task automatic check_reset_outputs();
        check("rst_ready", {63'h0, recv_data_ready}, 64'h0);
        check("rst_err",   {63'h0, recv_data_err},   64'h0);
        check("rst_valid", {63'h0, pkt_valid},       64'h0);
        check("rst_data",  pkt_data,                 64'h0);
        check("rst_drop",  {56'h0, drop_cnt},        64'h0);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n  = 1'b1;
        chk_en = 1'b1;

        // Single packet, held in the buffer to pin its value.
        pkt_ready = 1'b0;
        send_pkt(64'h0123_4567_89AB_CDEF, -1, 0);
        check("single_pin", pkt_data, 64'h0123_4567_89AB_CDEF);
        pkt_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        check("single_gone", {63'h0, pkt_valid}, 64'h0);

`ifdef LINK_PARITY_CHECK_EN
        send_pkt(64'h1111_2222_3333_4444, 2, 0);
        check("drop_pin", {56'h0, drop_cnt}, 64'h1);
        send_pkt(64'h5555_6666_7777_8888, -1, 0);
`else
        pkt_ready = 1'b0;
        send_pkt(64'h1111_2222_3333_4444, 2, 0);
        check("noparity_pin", pkt_data, 64'h1111_2222_3333_4444);
        check("noparity_drop", {56'h0, drop_cnt}, 64'h0);
        pkt_ready = 1'b1;
        repeat (2) @(posedge clk);
        #1;
`endif

        // Sender holds valid 5 extra cycles on the first flit.
        send_flit(16'hA5A5, 1'b0, 5, 0);
        send_flit(16'h1234, 1'b0, 0, 0);
        send_flit(16'h5678, 1'b0, 0, 0);
        send_flit(16'h9ABC, 1'b0, 0, 0);
        repeat (2) @(posedge clk);
        #1;

        // Backpressure: A and B fill the buffer, C's last flit waits.
        pkt_ready = 1'b0;
        send_pkt(64'hAAAA_0001_AAAA_0002, -1, 0);
        send_pkt(64'hBBBB_0001_BBBB_0002, -1, 0);
        send_pkt(64'hCCCC_0001_CCCC_0002, -1, 6);
        repeat (6) @(posedge clk);
        #1;
        check("bp_drain", 64'(exp_q.size()), 64'h0);

        // Reset in the middle of a packet.
        send_flit(16'h1357, 1'b0, 0, 0);
        send_flit(16'h2468, 1'b0, 0, 0);
        rst_n = 1'b0;
        exp_q.delete();
        cur_n    = 0;
        cur_bad  = 1'b0;
        exp_drop = 0;
        @(posedge clk);
        #1;
        check_reset_outputs();
        rst_n     = 1'b1;
        pkt_ready = 1'b0;
        send_pkt(64'hFFFF_0000_AAAA_5555, -1, 0);
        check("reset_pin", pkt_data, 64'hFFFF_0000_AAAA_5555);
        pkt_ready = 1'b1;
        repeat (4) @(posedge clk);
        #1;
        check("final_empty", {63'h0, pkt_valid}, 64'h0);

        chk_en = 1'b0;
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
